// File: rtl/axi3_mem_responder.sv
// AXI3 slave in front of a word-addressed on-chip memory: one read or write
// burst at a time, INCR/FIXED bursts, per-beat byte strobes, SLVERR reporting.
module axi3_mem_responder #(
    parameter int unsigned BIT_WIDTH   = 32,
    parameter int unsigned WSTRB_WIDTH = BIT_WIDTH / 8,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [31:0]            s_awaddr,
    input  logic [7:0]             s_awlen,
    input  logic [2:0]             s_awsize,
    input  logic [1:0]             s_awburst,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    input  logic [BIT_WIDTH-1:0]   s_wdata,
    input  logic [WSTRB_WIDTH-1:0] s_wstrb,
    input  logic                   s_wlast,
    output logic                   s_bvalid,
    input  logic                   s_bready,
    output logic [1:0]             s_bresp,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    input  logic [31:0]            s_araddr,
    input  logic [7:0]             s_arlen,
    input  logic [2:0]             s_arsize,
    input  logic [1:0]             s_arburst,
    output logic                   s_rvalid,
    input  logic                   s_rready,
    output logic [BIT_WIDTH-1:0]   s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rlast
);

    localparam int unsigned ADDR_LSB = $clog2(WSTRB_WIDTH);
    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        fixed;
        logic        err;
    } burst_t;

    logic [BIT_WIDTH-1:0] mem [DEPTH_WORDS];

    state_t               state_q, state_d;
    burst_t               burst_q, burst_d;
    logic [7:0]           beat_q, beat_d;
    logic                 werr_q, werr_d;
    logic                 rd_more_q, rd_more_d;
    logic                 awready_q, awready_d;
    logic                 arready_q, arready_d;
    logic                 wready_q, wready_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 rvalid_q, rvalid_d;
    logic [BIT_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;
    logic                 rlast_q, rlast_d;

    logic                 aw_hs;
    logic                 ar_hs;
    logic                 beat_ok;
    logic                 final_beat;
    logic [31:0]          next_addr;
    logic [IDX_W-1:0]     mem_idx;
    logic                 mem_we;

    function automatic logic setup_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'(ADDR_LSB)) || burst[1];
    endfunction

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (off >> ADDR_LSB) < 32'(DEPTH_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> ADDR_LSB);
    endfunction

    // A pending write blocks AR in the same cycle so that write always wins.
    assign s_awready = awready_q;
    assign s_arready = arready_q & ~s_awvalid;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_rlast   = rlast_q;

    assign aw_hs      = s_awvalid & awready_q;
    assign ar_hs      = s_arvalid & s_arready;
    assign beat_ok    = in_range(burst_q.addr);
    assign final_beat = (beat_q == burst_q.len);
    assign next_addr  = burst_q.fixed ? burst_q.addr : burst_q.addr + 32'(WSTRB_WIDTH);
    assign mem_idx    = word_idx(burst_q.addr);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        werr_d    = werr_q;
        rd_more_d = rd_more_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    burst_d = '{addr:  s_awaddr,
                                len:   s_awlen,
                                fixed: (s_awburst == BURST_FIXED),
                                err:   setup_err(s_awsize, s_awburst)};
                    beat_d  = 8'd0;
                    werr_d  = setup_err(s_awsize, s_awburst);
                    state_d = WDATA;
                end else if (ar_hs) begin
                    burst_d   = '{addr:  s_araddr,
                                  len:   s_arlen,
                                  fixed: (s_arburst == BURST_FIXED),
                                  err:   setup_err(s_arsize, s_arburst)};
                    beat_d    = 8'd0;
                    rd_more_d = 1'b1;
                    state_d   = RDATA;
                end
            end

            WDATA: begin
                if (s_wvalid && wready_q) begin
                    mem_we = ~burst_q.err & beat_ok;
                    if (!beat_ok || (s_wlast != final_beat)) begin
                        werr_d = 1'b1;
                    end
                    burst_d.addr = next_addr;
                    beat_d       = beat_q + 8'd1;
                    if (final_beat) begin
                        bvalid_d = 1'b1;
                        bresp_d  = werr_d ? RESP_SLVERR : RESP_OKAY;
                        state_d  = WRESP;
                    end
                end
            end

            WRESP: begin
                if (s_bready) begin
                    bvalid_d = 1'b0;
                    bresp_d  = RESP_OKAY;
                    state_d  = IDLE;
                end
            end

            RDATA: begin
                // Output register doubles as the memory read stage; refill it
                // whenever it is empty or being drained.
                if (rvalid_q && s_rready && rlast_q) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    state_d  = IDLE;
                end else if (!rvalid_q || s_rready) begin
                    if (rd_more_q) begin
                        rvalid_d     = 1'b1;
                        rdata_d      = (burst_q.err || !beat_ok) ? '0 : mem[mem_idx];
                        rresp_d      = (burst_q.err || !beat_ok) ? RESP_SLVERR : RESP_OKAY;
                        rlast_d      = final_beat;
                        rd_more_d    = ~final_beat;
                        burst_d.addr = next_addr;
                        beat_d       = beat_q + 8'd1;
                    end else begin
                        rvalid_d = 1'b0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        awready_d = (state_d == IDLE);
        arready_d = (state_d == IDLE);
        wready_d  = (state_d == WDATA);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            burst_q   <= '0;
            beat_q    <= '0;
            werr_q    <= 1'b0;
            rd_more_q <= 1'b0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            werr_q    <= werr_d;
            rd_more_q <= rd_more_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // Memory array is never reset; strobed byte-lane writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < WSTRB_WIDTH; i++) begin
                if (s_wstrb[i]) begin
                    mem[mem_idx][8*i +: 8] <= s_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi3_mem_responder.sv
// Scoreboard bench for axi3_mem_responder: a byte-accurate memory model
// predicts B responses and R beats, compared as the DUT produces them.
module tb_axi3_mem_responder;

    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        resetn;
    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [31:0] model [0:DEPTH-1];
    logic [31:0] wd_tab [0:15];
    logic [3:0]  ws_tab [0:15];
    int          total;
    int          bad;

    axi3_mem_responder dut (
        .clk(clk), .resetn(resetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [2:0] size,
                               input int lastbad);
        logic [31:0] a, idx;
        logic serr, err;
        a    = addr;
        serr = (size != 3'd2) || burst[1];
        err  = serr;
        for (int i = 0; i <= int'(len); i++) begin
            idx = (a - BASE) >> 2;
            if (idx >= DEPTH) err = 1'b1;
            else if (!serr)
                for (int b = 0; b < 4; b++)
                    if (ws_tab[i][b]) model[idx[11:0]][8*b +: 8] = wd_tab[i][8*b +: 8];
            if (i == lastbad) err = 1'b1;
            if (burst != 2'b00) a = a + 32'd4;
        end
        bq.push_back(err ? 2'b10 : 2'b00);
    endtask

    task automatic model_read(input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [2:0] size);
        logic [31:0] a, idx;
        logic serr, oor;
        rbeat_t beat;
        a    = addr;
        serr = (size != 3'd2) || burst[1];
        for (int i = 0; i <= int'(len); i++) begin
            idx       = (a - BASE) >> 2;
            oor       = (idx >= DEPTH);
            beat.data = (serr || oor) ? 32'd0 : model[idx[11:0]];
            beat.resp = (serr || oor) ? 2'b10 : 2'b00;
            beat.last = (i == int'(len));
            rq.push_back(beat);
            if (burst != 2'b00) a = a + 32'd4;
        end
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        int n;
        s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awsize = size;
        s_awvalid = 1'b1;
        n = 0;
        while (!s_awready && n < 20) begin tick(); n++; end
        total++;
        if (s_awready !== 1'b1) begin
            bad++;
            $display("FAIL aw_handshake: awready=%b required 1", s_awready);
        end
        tick();
        s_awvalid = 1'b0;
    endtask

    task automatic w_phase(input logic [7:0] len, input int lastbad);
        int n;
        for (int i = 0; i <= int'(len); i++) begin
            s_wvalid = 1'b1;
            s_wdata  = wd_tab[i];
            s_wstrb  = ws_tab[i];
            s_wlast  = (i == int'(len)) ^ (i == lastbad);
            n = 0;
            while (!s_wready && n < 20) begin tick(); n++; end
            total++;
            if (s_wready !== 1'b1) begin
                bad++;
                $display("FAIL w_handshake beat %0d: wready=%b required 1", i, s_wready);
            end
            tick();
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        total++;
        if (s_bvalid !== 1'b1) begin
            bad++;
            $display("FAIL b_latency: bvalid=%b required 1 one cycle after last beat", s_bvalid);
        end
    endtask

    task automatic b_phase(input int delay);
        int n;
        logic [1:0] exp;
        n = 0;
        while (!s_bvalid && n < 20) begin tick(); n++; end
        exp = (bq.size() > 0) ? bq[0] : 2'bxx;
        for (int d = 0; d < delay; d++) begin
            total++;
            if (s_bvalid !== 1'b1 || s_bresp !== exp) begin
                bad++;
                $display("FAIL b_stall: bvalid=%b bresp=%b required 1/%b", s_bvalid, s_bresp, exp);
            end
            tick();
        end
        s_bready = 1'b1;
        total++;
        if (s_bvalid !== 1'b1 || s_bresp !== exp) begin
            bad++;
            $display("FAIL bresp: bvalid=%b bresp=%b required 1/%b", s_bvalid, s_bresp, exp);
        end
        tick();
        s_bready = 1'b0;
        if (bq.size() > 0) void'(bq.pop_front());
        total++;
        if (s_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL b_drop: bvalid=%b required 0 after handshake", s_bvalid);
        end
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        int n;
        s_araddr = addr; s_arlen = len; s_arburst = burst; s_arsize = size;
        s_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_arready && n < 20) begin @(posedge clk); #2; n++; end
        total++;
        if (s_arready !== 1'b1) begin
            bad++;
            $display("FAIL ar_handshake: arready=%b required 1", s_arready);
        end
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
    endtask

    // pat 0: rready always high; pat 1: rready repeats 1,0,0,1.
    task automatic r_phase(input logic [7:0] len, input int pat);
        int got, lat, k;
        logic first;
        got = 0; lat = 1; k = 0; first = 1'b1;
        while (got <= int'(len) && lat < 200) begin
            s_rready = (pat == 0) || (k % 4 == 0) || (k % 4 == 3);
            k++;
            #1;
            if (s_rvalid) begin
                if (first) begin
                    total++;
                    if (lat != 2) begin
                        bad++;
                        $display("FAIL r_latency: first rvalid %0d cycles after AR, required 2", lat);
                    end
                    first = 1'b0;
                end
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL r_extra: unexpected beat data=%h", s_rdata);
                end else if (s_rdata !== rq[0].data || s_rresp !== rq[0].resp ||
                             s_rlast !== rq[0].last) begin
                    bad++;
                    $display("FAIL r_beat %0d: data=%h resp=%b last=%b required %h/%b/%b",
                             got, s_rdata, s_rresp, s_rlast, rq[0].data, rq[0].resp, rq[0].last);
                end
                if (s_rready && rq.size() > 0) begin
                    void'(rq.pop_front());
                    got++;
                end
            end
            @(posedge clk);
            #1;
            lat++;
        end
        s_rready = 1'b0;
        total++;
        if (got != int'(len) + 1) begin
            bad++;
            $display("FAIL r_count: got %0d beats, required %0d", got, int'(len) + 1);
        end
        total++;
        if (s_rvalid !== 1'b0 || s_awready !== 1'b1) begin
            bad++;
            $display("FAIL r_end: rvalid=%b awready=%b required 0/1", s_rvalid, s_awready);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input int lastbad, input int bdelay);
        model_write(addr, len, burst, size, lastbad);
        aw_phase(addr, len, burst, size);
        w_phase(len, lastbad);
        b_phase(bdelay);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int pat);
        model_read(addr, len, burst, size);
        ar_phase(addr, len, burst, size);
        r_phase(len, pat);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast} !== 6'b0 ||
            s_bresp !== 2'b00 || s_rresp !== 2'b00 || s_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: aw=%b ar=%b w=%b b=%b r=%b last=%b bresp=%b rresp=%b rdata=%h required all 0",
                     s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast, s_bresp, s_rresp, s_rdata);
        end
        resetn = 1'b1;
        tick();
        total++;
        if (s_awready !== 1'b1 || s_arready !== 1'b1 || s_wready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: awready=%b arready=%b wready=%b required 1/1/0",
                     s_awready, s_arready, s_wready);
        end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) begin
            wd_tab[i] = 32'h11 * (i + 1);
            ws_tab[i] = 4'hF;
        end
        do_write(32'h100, 8'd3, 2'b01, 3'd2, -1, 0);
        do_read(32'h100, 8'd3, 2'b01, 3'd2, 0);
    endtask

    task automatic test_strobe();
        wd_tab[0] = 32'hFFFF_FFFF; ws_tab[0] = 4'hF;
        do_write(32'h200, 8'd0, 2'b01, 3'd2, -1, 0);
        wd_tab[0] = 32'hAABB_CCDD; ws_tab[0] = 4'b0101;
        do_write(32'h200, 8'd0, 2'b01, 3'd2, -1, 2);
        do_read(32'h200, 8'd0, 2'b01, 3'd2, 0);
    endtask

    task automatic test_collision();
        wd_tab[0] = 32'h7777_0001; ws_tab[0] = 4'hF;
        model_write(32'h700, 8'd0, 2'b01, 3'd2, -1);
        model_read(32'h100, 8'd0, 2'b01, 3'd2);
        s_awaddr = 32'h700; s_awlen = 8'd0; s_awburst = 2'b01; s_awsize = 3'd2;
        s_araddr = 32'h100; s_arlen = 8'd0; s_arburst = 2'b01; s_arsize = 3'd2;
        s_awvalid = 1'b1;
        s_arvalid = 1'b1;
        #1;
        total++;
        if (s_awready !== 1'b1 || s_arready !== 1'b0) begin
            bad++;
            $display("FAIL collide_ready: awready=%b arready=%b required 1/0", s_awready, s_arready);
        end
        @(posedge clk);
        #1;
        s_awvalid = 1'b0;
        w_phase(8'd0, -1);
        total++;
        if (s_arready !== 1'b0) begin
            bad++;
            $display("FAIL collide_hold: arready=%b required 0 before B handshake", s_arready);
        end
        b_phase(1);
        total++;
        if (s_arready !== 1'b1) begin
            bad++;
            $display("FAIL collide_ar: arready=%b required 1 the cycle after B handshake", s_arready);
        end
        tick();
        s_arvalid = 1'b0;
        r_phase(8'd0, 0);
        do_read(32'h700, 8'd0, 2'b01, 3'd2, 0);
    endtask

    task automatic test_errors();
        wd_tab[0] = 32'h5A5A_1234; ws_tab[0] = 4'hF;
        do_write(DEPTH * 4 - 4, 8'd0, 2'b01, 3'd2, -1, 0);
        do_read(DEPTH * 4 - 4, 8'd1, 2'b01, 3'd2, 0);
        for (int i = 0; i < 4; i++) begin
            wd_tab[i] = 32'hDEAD_0000 + i;
            ws_tab[i] = 4'hF;
        end
        do_write(32'h100, 8'd3, 2'b10, 3'd2, -1, 0);
        do_read(32'h100, 8'd3, 2'b01, 3'd2, 0);
        do_read(32'h100, 8'd0, 2'b01, 3'd1, 0);
        wd_tab[0] = 32'h8000_0000; wd_tab[1] = 32'h8000_0001;
        do_write(32'h800, 8'd1, 2'b01, 3'd2, 0, 0);
        do_read(32'h800, 8'd1, 2'b01, 3'd2, 0);
    endtask

    task automatic test_fixed();
        for (int i = 0; i < 3; i++) begin
            wd_tab[i] = 32'hC0C0_0000 + i;
            ws_tab[i] = 4'hF;
        end
        wd_tab[1] = 32'h0000_00C1;
        ws_tab[1] = 4'b0001;
        do_write(32'h900, 8'd2, 2'b00, 3'd2, -1, 0);
        do_read(32'h900, 8'd2, 2'b00, 3'd2, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) begin
            wd_tab[i] = 32'h5000_0000 + 32'h1111 * i;
            ws_tab[i] = 4'hF;
        end
        do_write(32'h500, 8'd7, 2'b01, 3'd2, -1, 0);
        do_read(32'h500, 8'd7, 2'b01, 3'd2, 1);
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 3; i++) begin
            wd_tab[i] = 32'hA000_0000 + i;
            ws_tab[i] = 4'hF;
        end
        do_write(32'h600, 8'd2, 2'b01, 3'd2, -1, 0);
        aw_phase(32'h600, 8'd7, 2'b01, 3'd2);
        for (int i = 0; i < 2; i++) begin
            s_wvalid = 1'b1;
            s_wdata  = 32'hB000_0000 + i;
            s_wstrb  = 4'hF;
            s_wlast  = 1'b0;
            n = 0;
            while (!s_wready && n < 20) begin tick(); n++; end
            tick();
            model[10'h180 + i] = 32'hB000_0000 + i;
        end
        resetn   = 1'b0;
        s_wvalid = 1'b0;
        #1;
        total++;
        if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid: aw=%b ar=%b w=%b b=%b r=%b required all 0",
                     s_awready, s_arready, s_wready, s_bvalid, s_rvalid);
        end
        tick();
        resetn = 1'b1;
        tick();
        total++;
        if (s_awready !== 1'b1 || s_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_release: awready=%b bvalid=%b required 1/0", s_awready, s_bvalid);
        end
        do_read(32'h600, 8'd2, 2'b01, 3'd2, 0);
    endtask

    initial begin
        total = 0; bad = 0;
        resetn = 1'b0;
        s_awvalid = 1'b0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
        s_bready = 1'b0;
        s_arvalid = 1'b0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_rready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'd0;
        for (int i = 0; i < 16; i++) begin wd_tab[i] = 32'd0; ws_tab[i] = 4'h0; end

        test_reset();
        test_incr();
        test_strobe();
        test_collision();
        test_errors();
        test_fixed();
        test_backpressure();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi3_mem_responder.md
Name: axi3_mem_responder

Overview:
AXI3 slave (responder) fronting a word-addressed on-chip memory. It is the far end of the cache's mem_d_*/mem_i_* master ports. Used as the memory model in simulation and as the BRAM backing store on FPGA. Serves one burst at a time (read or write), INCR and FIXED bursts, with per-beat byte strobes.

Parameters:
BIT_WIDTH, 32, data bus width in bits
WSTRB_WIDTH, BIT_WIDTH/8, strobe width and bytes per beat
DEPTH_WORDS, 4096, memory depth in BIT_WIDTH words
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
clk  in  1  clock; all logic on rising edge
resetn  in  1  asynchronous, active-low reset
s_awvalid/s_awready  in/out  1/1  write address handshake
s_awaddr, s_awlen, s_awsize, s_awburst  in  32, 8, 3, 2  write address, beats-1, log2 bytes, burst type
s_wvalid/s_wready  in/out  1/1  write data handshake
s_wdata, s_wstrb, s_wlast  in  BIT_WIDTH, WSTRB_WIDTH, 1  write beat
s_bvalid/s_bready  out/in  1/1  write response handshake; s_bresp out 2
s_arvalid/s_arready  in/out  1/1  read address handshake
s_araddr, s_arlen, s_arsize, s_arburst  in  32, 8, 3, 2  read address fields
s_rvalid/s_rready  out/in  1/1  read data handshake
s_rdata, s_rresp, s_rlast  out  BIT_WIDTH, 2, 1  read beat

Behaviour:
- Reset (resetn low, async): FSM to IDLE; all ready/valid outputs, s_bresp, s_rresp, s_rdata, s_rlast = 0. Memory contents are not cleared. Reset mid-burst abandons the burst with no response.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE: s_awready = s_arready = 1, registered, so both are high from the first cycle after reset release.
  - On AW handshake: latch addr, len, and the error flag; go to WDATA.
  - Else on AR handshake: latch fields; go to RDATA.
  - Simultaneous valid: write wins; s_arready drops, AR stays pending until the write completes.
- Burst setup error (SLVERR for the whole burst): awsize/arsize != log2(WSTRB_WIDTH), or burst == WRAP (2'b10) or reserved (2'b11). An errored write absorbs its beats without touching memory. An errored read returns zero data.
- Address step per beat: INCR (2'b01) adds WSTRB_WIDTH; FIXED (2'b00) holds. Word index = (addr - BASE_ADDR) >> log2(WSTRB_WIDTH). Low address bits below beat size are ignored.
- Out-of-range beat (index >= DEPTH_WORDS, including addr < BASE_ADDR): write suppressed, read data 0, burst marked SLVERR. Address arithmetic is 32-bit and wraps modulo 2^32.
- WDATA: s_wready = 1.
  - Each handshake writes byte lanes where s_wstrb[i]=1; other bytes unchanged.
  - Beat count is driven by awlen+1 only. The final beat is number awlen+1.
  - s_wlast != (beat == final) on any beat sets SLVERR.
  - After the final beat go to WRESP.
- WRESP: s_bvalid = 1 the cycle after the final W beat. s_bresp = 2'b00 (OKAY) or 2'b10 (SLVERR). Held stable until s_bready; then IDLE.
- RDATA: memory read latency is 1 cycle.
  - First s_rvalid occurs 2 cycles after the AR handshake.
  - s_rdata, s_rresp, s_rlast are held stable while s_rvalid && !s_rready.
  - Throughput is 1 beat/cycle when s_rready stays high (next-word prefetch).
  - s_rlast = 1 only on beat arlen+1. s_rresp is per beat.
  - After the last handshake go to IDLE.
- Read-after-write to the same word returns the new data. A write completes before its B response, so ordering is guaranteed.

Test Plan:
- Write INCR len=3 at 0x100, wdata 0x11..0x44, strb 4'hF, bready=1 -> bresp OKAY one cycle after 4th beat; read len=3 at 0x100 returns 0x11,0x22,0x33,0x44, rlast only on beat 4.
- Write 0xAABBCCDD with strb 4'b0101 over word 0xFFFFFFFF -> read returns 0xFFBBFFDD.
- AW and AR valid same cycle (different addresses) -> write served first, AR accepted the cycle after B handshake; arready low until then.
- Read INCR len=1 at byte DEPTH_WORDS*4-4 -> beat 1 OKAY with stored data, beat 2 rdata 0 SLVERR; write with awburst=2'b10 -> all beats absorbed, bresp SLVERR, memory unchanged.
- Read len=7 with rready toggling 1,0,0,1 pattern -> every beat delivered once, in order, data stable across stalls.
- Assert resetn low during beat 2 of a len=7 write -> outputs 0 immediately; after release awready=1; beats 1 and 2 already written remain in memory.
